// File: rtl/sha_digest_finalize_stage.sv
// SHA-256 finalize stage: midstate add, leading-zero difficulty test, hit FIFO with valid/ready drain.
// Optional build macro SHA_FINALIZE_HIT_COUNT_EN adds hit_count_o (saturating count of FIFO writes).
module sha_digest_finalize_stage #(
    parameter int ZERO_BITS  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [255:0] state_i,
    input  logic [255:0] midstate_i,
    input  logic [31:0]  nonce_i,
    output logic         hit_valid_o,
    input  logic         hit_ready_i,
    output logic [31:0]  hit_nonce_o,
    output logic [255:0] hit_digest_o,
`ifdef SHA_FINALIZE_HIT_COUNT_EN
    output logic [31:0]  hit_count_o,
`endif
    output logic         overflow_o
);

    localparam int DATA_W  = 256;
    localparam int WORD_W  = 32;
    localparam int ENTRY_W = DATA_W + WORD_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    function automatic logic [DATA_W-1:0] add_words(input logic [DATA_W-1:0] x,
                                                    input logic [DATA_W-1:0] y);
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W / WORD_W; k++) begin
            r[k*WORD_W +: WORD_W] = x[k*WORD_W +: WORD_W] + y[k*WORD_W +: WORD_W];
        end
        return r;
    endfunction

`ifdef SHA_FINALIZE_HIT_COUNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
`endif

    logic              vld_p0;
    logic [DATA_W-1:0] dig_p0;
    logic [WORD_W-1:0] nonce_p0;
    logic              vld_p1;
    logic [DATA_W-1:0] dig_p1;
    logic [WORD_W-1:0] nonce_p1;

    // S1: per-word modular add of final round state and midstate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= valid_i;
        end
    end

    always_ff @(posedge clk) begin
        dig_p0   <= add_words(state_i, midstate_i);
        nonce_p0 <= nonce_i;
    end

    // S2: difficulty test; vld_p1 only marks hits, misses end here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0 && (dig_p0[DATA_W-1 -: ZERO_BITS] == '0);
        end
    end

    always_ff @(posedge clk) begin
        dig_p1   <= dig_p0;
        nonce_p1 <= nonce_p0;
    end

    // S3: hit FIFO
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               push;
    logic               pop;
    logic               wr_en;
    logic [ENTRY_W-1:0] head;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign push  = vld_p1;
    assign pop   = hit_valid_o & hit_ready_i;
    // A full FIFO still accepts a push in the same cycle its head is popped
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {nonce_p1, dig_p1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !wr_en) begin
                count <= count - CNT_W'(1);
            end
            if (push && full && !pop) begin
                overflow_o <= 1'b1;
            end
        end
    end

`ifdef SHA_FINALIZE_HIT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_o <= '0;
        end else if (wr_en) begin
            hit_count_o <= sat_inc(hit_count_o);
        end
    end
`endif

    // Head data is forced to zero while empty so outputs read 0 out of reset
    assign head         = mem[rd_ptr];
    assign hit_valid_o  = (count != '0);
    assign hit_nonce_o  = hit_valid_o ? head[ENTRY_W-1 -: WORD_W] : '0;
    assign hit_digest_o = hit_valid_o ? head[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_sha_digest_finalize_stage.sv
// Scoreboard bench for sha_digest_finalize_stage: directed corner cases plus random beats
// checked against an arithmetic digest model and a queue model of the hit FIFO.
module tb_sha_digest_finalize_stage;

    localparam int ZB    = 32;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i;
    logic [255:0] state_i;
    logic [255:0] midstate_i;
    logic [31:0]  nonce_i;
    logic         hit_valid_o;
    logic         ready;
    logic [31:0]  hit_nonce_o;
    logic [255:0] hit_digest_o;
    logic         overflow_o;
`ifdef SHA_FINALIZE_HIT_COUNT_EN
    logic [31:0]  hit_count_o;
`endif

    always #5 clk = ~clk;

    sha_digest_finalize_stage #(.ZERO_BITS(ZB), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .state_i      (state_i),
        .midstate_i   (midstate_i),
        .nonce_i      (nonce_i),
        .hit_valid_o  (hit_valid_o),
        .hit_ready_i  (ready),
        .hit_nonce_o  (hit_nonce_o),
        .hit_digest_o (hit_digest_o),
`ifdef SHA_FINALIZE_HIT_COUNT_EN
        .hit_count_o  (hit_count_o),
`endif
        .overflow_o   (overflow_o)
    );

    typedef struct {
        int unsigned  t;
        logic [31:0]  nonce;
        logic [255:0] digest;
    } hit_t;

    hit_t        issued_q[$];
    hit_t        model_q[$];
    logic        model_ovf = 1'b0;
    longint      model_cnt = 0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] ref_digest(input logic [255:0] s, input logic [255:0] m);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) begin
            longint unsigned sum;
            sum = 64'(s[k*32 +: 32]) + 64'(m[k*32 +: 32]);
            d[k*32 +: 32] = 32'(sum % 64'h1_0000_0000);
        end
        return d;
    endfunction

    function automatic bit ref_hit(input logic [255:0] d);
        return (d >> (256 - ZB)) == 256'd0;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of input; expected hits go to the scoreboard at issue time
    task automatic drive_beat(input logic v, input logic [255:0] s, input logic [255:0] m,
                              input logic [31:0] n);
        logic [255:0] d;
        valid_i    = v;
        state_i    = s;
        midstate_i = m;
        nonce_i    = n;
        if (v && rst_n) begin
            d = ref_digest(s, m);
            if (ref_hit(d)) issued_q.push_back('{cyc, n, d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_beat(1'b0, '0, '0, '0);
    endtask

    task automatic rand_beat(input logic [31:0] n, input bit want_hit);
        logic [255:0] s;
        logic [255:0] m;
        for (int k = 0; k < 8; k++) begin
            s[k*32 +: 32] = $urandom;
            m[k*32 +: 32] = $urandom;
        end
        if (want_hit) s[255:224] = 32'h0 - m[255:224];
        drive_beat(1'b1, s, m, n);
    endtask

    task automatic pulse_reset(input int n);
        valid_i = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) rand_beat($urandom, 1'b1);
        valid_i = 1'b0;
        rst_n   = 1'b1;
        idle(1);
    endtask

    // Monitor: compare outputs to the FIFO model, then apply the coming edge's pop/push
    always @(negedge clk) begin
        bit   full;
        bit   pop;
        hit_t h;
        if (!rst_n) begin
            check("rst_hit_valid", 256'(hit_valid_o), 256'(0));
            check("rst_overflow", 256'(overflow_o), 256'(0));
            check("rst_nonce", 256'(hit_nonce_o), 256'(0));
            check("rst_digest", hit_digest_o, 256'(0));
`ifdef SHA_FINALIZE_HIT_COUNT_EN
            check("rst_hit_count", 256'(hit_count_o), 256'(0));
`endif
            issued_q.delete();
            model_q.delete();
            model_ovf = 1'b0;
            model_cnt = 0;
        end else begin
            check("hit_valid", 256'(hit_valid_o), 256'(model_q.size() != 0));
            if (model_q.size() != 0) begin
                check("hit_nonce", 256'(hit_nonce_o), 256'(model_q[0].nonce));
                check("hit_digest", hit_digest_o, model_q[0].digest);
            end
            check("overflow", 256'(overflow_o), 256'(model_ovf));
`ifdef SHA_FINALIZE_HIT_COUNT_EN
            check("hit_count", 256'(hit_count_o), 256'(model_cnt));
`endif
            full = (model_q.size() == DEPTH);
            pop  = ready && (model_q.size() != 0);
            if (pop) void'(model_q.pop_front());
            while (issued_q.size() != 0 && issued_q[0].t + 2 <= cyc) begin
                h = issued_q.pop_front();
                if (full && !pop) begin
                    model_ovf = 1'b1;
                end else begin
                    model_q.push_back(h);
                    model_cnt++;
                end
            end
        end
    end

    initial begin
        int budget;
        rst_n      = 1'b0;
        valid_i    = 1'b1;
        state_i    = '0;
        midstate_i = '0;
        nonce_i    = '0;
        ready      = 1'b0;

        // Reset held with live beats on the input
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rand_beat(i, 1'b1);
        valid_i = 1'b0;
        rst_n   = 1'b1;
        idle(4);

        // Carry out of word a is dropped: FFFF_FFFF + 1 -> 0
        ready = 1'b1;
        drive_beat(1'b1, {32'hFFFF_FFFF, 224'd0}, {32'h0000_0001, 224'd0}, 32'h1234);
        idle(5);

        // d0 = 1 misses; d0 = 0 with d1 MSB set sits just past the 32-bit field
        drive_beat(1'b1, {32'h0000_0001, 224'd0}, 256'd0, 32'hAA01);
        drive_beat(1'b1, {32'h0, 32'h8000_0000, 192'd0}, 256'd0, 32'hAA02);
        idle(5);

        // Fill and overflow: five hits against a stalled consumer, then drain
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) rand_beat(i, 1'b1);
        idle(5);
        ready = 1'b1;
        idle(8);

        // Full FIFO: pop and push land on the same edge
        pulse_reset(2);
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) rand_beat(i, 1'b1);
        idle(4);
        rand_beat(32'h55, 1'b1);
        idle(1);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        idle(3);
        ready = 1'b1;
        idle(8);

        // Reset with two hits buffered and two more in the pipe
        ready = 1'b0;
        rand_beat(32'h61, 1'b1);
        rand_beat(32'h62, 1'b1);
        idle(4);
        rand_beat(32'h63, 1'b1);
        rand_beat(32'h64, 1'b1);
        pulse_reset(2);
        idle(6);

        // Random traffic with a random consumer
        for (int i = 0; i < 600; i++) begin
            ready = ($urandom_range(0, 99) < 50);
            if ($urandom_range(0, 99) < 70) rand_beat($urandom, ($urandom_range(0, 99) < 40));
            else idle(1);
        end

        // Bounded drain
        valid_i = 1'b0;
        ready   = 1'b1;
        budget  = 0;
        while ((model_q.size() != 0 || issued_q.size() != 0) && budget < 200) begin
            idle(1);
            budget++;
        end
        n_checks++;
        if (budget >= 200) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, required 0", model_q.size());
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
